// File: rtl/req_arb_pkg.sv
// Shared constants, FSM state encoding and one-hot helper for the request arbiter and its consumers.
package req_arb_pkg;

  localparam int N    = 8;
  localparam int IDXW = 3;

  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;

  function automatic logic [N-1:0] onehot(input logic [IDXW-1:0] idx);
    return {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/req_onehot_arbiter_rr_pick.sv
// Combinational winner selection over the pending vector.
// REQ_ARB_FIXED_PRIO_EN selects highest-index fixed priority instead of round-robin from ptr.
module rr_pick
  import req_arb_pkg::*;
(
  input  logic [N-1:0]    pending,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] win_idx,
  output logic            win_valid
);

`ifdef REQ_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Ascending scan, so the last hit (highest index) wins.
  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pending[i]) begin
        win_idx   = IDXW'(i);
        win_valid = 1'b1;
      end
    end
  end
`else
  logic [IDXW-1:0] cand;

  // Scan from farthest to nearest offset; the nearest set bit at or after ptr is written last.
  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    cand      = '0;
    for (int k = N-1; k >= 0; k--) begin
      cand = ptr + IDXW'(k);
      if (pending[cand]) begin
        win_idx   = cand;
        win_valid = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/req_onehot_arbiter.sv
// Edge-capturing one-hot request arbiter feeding the 8-to-3 encoder (din/en).
// Round-robin by default; REQ_ARB_FIXED_PRIO_EN selects fixed priority (bit 7 highest).
module req_onehot_arbiter
  import req_arb_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ack,
  input  logic         clr_overrun,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic [N-1:0] pending,
  output logic         overrun
);

  logic [N-1:0]    req_q;
  logic [N-1:0]    edges;
  logic [N-1:0]    clr_mask;
  logic [N-1:0]    ovr_hit;
  logic            state;
  logic            ack_done;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] cur_idx;
  logic [IDXW-1:0] win_idx;
  logic            win_valid;

  assign edges    = req & ~req_q;
  assign ack_done = (state == GRANT) && ack;
  assign clr_mask = ack_done ? onehot(cur_idx) : '0;
  // A fresh edge on the line being acknowledged re-arms it instead of counting as an overrun.
  assign ovr_hit  = edges & pending & ~clr_mask;

  rr_pick u_pick (
    .pending   (pending),
    .ptr       (ptr),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q       <= '0;
      pending     <= '0;
      overrun     <= 1'b0;
      grant       <= '0;
      grant_valid <= 1'b0;
      state       <= IDLE;
      ptr         <= '0;
      cur_idx     <= '0;
    end else begin
      req_q   <= req;
      pending <= (pending & ~clr_mask) | edges;
      overrun <= (|ovr_hit) | (overrun & ~clr_overrun);
      if (state == IDLE) begin
        if (win_valid) begin
          grant       <= onehot(win_idx);
          grant_valid <= 1'b1;
          cur_idx     <= win_idx;
          state       <= GRANT;
        end
      end else if (ack) begin
        grant       <= '0;
        grant_valid <= 1'b0;
        state       <= IDLE;
`ifndef REQ_ARB_FIXED_PRIO_EN
        ptr         <= cur_idx + 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_req_onehot_arbiter.sv
// Scoreboard bench for req_onehot_arbiter: a behavioural event/turn model predicts grants and status.
module tb_req_onehot_arbiter;
  import req_arb_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic         ack = 1'b0;
  logic         clr_overrun = 1'b0;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [N-1:0] pending;
  logic         overrun;

  int errors = 0;
  int checks = 0;

  req_onehot_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .ack         (ack),
    .clr_overrun (clr_overrun),
    .grant       (grant),
    .grant_valid (grant_valid),
    .pending     (pending),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a set of outstanding events, a turn pointer, and at most one holder.
  bit          m_pend [N];
  bit          m_prev [N];
  int          m_ptr;
  int          m_cur;
  bit          m_busy;
  bit          m_ovf;
  logic [N-1:0] exp_q[$];

  function automatic logic [N-1:0] m_pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic int m_choose();
    int w;
    w = -1;
`ifdef REQ_ARB_FIXED_PRIO_EN
    for (int i = N-1; i >= 0; i--)
      if (w < 0 && m_pend[i]) w = i;
`else
    for (int k = 0; k < N; k++)
      if (w < 0 && m_pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
`endif
    return w;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_prev[i] = 0; end
      m_ptr = 0; m_cur = 0; m_busy = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      bit ev [N];
      int done, w;
      bit set_ovf;
      done = (m_busy && ack) ? m_cur : -1;
      w = m_busy ? -1 : m_choose();
      set_ovf = 0;
      for (int i = 0; i < N; i++) begin
        ev[i] = req[i] && !m_prev[i];
        if (ev[i] && m_pend[i] && i != done) set_ovf = 1;
      end
      m_ovf = set_ovf || (m_ovf && !clr_overrun);
      if (done >= 0) begin
        m_pend[done] = 0;
        m_busy = 0;
`ifndef REQ_ARB_FIXED_PRIO_EN
        m_ptr = (done + 1) % N;
`endif
      end else if (w >= 0) begin
        m_busy = 1;
        m_cur = w;
        exp_q.push_back(onehot(IDXW'(w)));
      end
      for (int i = 0; i < N; i++) begin
        if (ev[i]) m_pend[i] = 1;
        m_prev[i] = req[i];
      end
    end
  end

  // Monitor: pops the scoreboard on each newly presented grant and checks status every cycle.
  logic gv_last = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      gv_last = 1'b0;
    end else begin
      if (grant_valid && !gv_last) begin
        if (exp_q.size() == 0) chk("sb_unexpected_grant", grant, '0);
        else chk("sb_grant", grant, exp_q.pop_front());
      end
      chk("grant_valid", grant_valid, m_busy);
      chk("grant_hold", grant, m_busy ? onehot(IDXW'(m_cur)) : '0);
      chk("pending", pending, m_pend_vec());
      chk("overrun", overrun, m_ovf);
      gv_last = grant_valid;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_gv();
    bit found;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (grant_valid) found = 1;
    end
    chk("wait_grant_valid", found, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; ack = 1'b0; clr_overrun = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_grant", grant, '0);
    chk("rst_gv", grant_valid, 1'b0);
    chk("rst_pending", pending, '0);
    chk("rst_overrun", overrun, 1'b0);

    // Single request on line 2.
    req = 8'h04;
    cyc(1);
    chk("single_pending", pending, 8'h04);
    cyc(1);
    chk("single_grant", grant, 8'h04);
    chk("single_enc_y", $clog2(grant), 2);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    chk("single_release", {grant_valid, grant}, '0);
    req = '0;
    cyc(3);

    // All lines rising together with ack tied high.
    ack = 1'b1;
    req = 8'hFF;
    cyc(20);
    chk("fair_drained", pending, '0);
    req = '0; ack = 1'b0;
    cyc(2);

    // Long hold without ack; a second request arrives mid-hold.
    req = 8'h20;
    wait_gv();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) req = 8'h22;
      cyc(1);
      chk("hold_grant", grant, 8'h20);
    end
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    wait_gv();
    chk("hold_next_grant", grant, 8'h02);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0; req = '0;
    cyc(3);

    // Overrun on line 3, then clear.
    req = 8'h08;
    cyc(2);
    req = '0;
    cyc(1);
    req = 8'h08;
    cyc(2);
    chk("ovr_set", overrun, 1'b1);
    cyc(2);
    chk("ovr_sticky", overrun, 1'b1);
    clr_overrun = 1'b1;
    cyc(1);
    clr_overrun = 1'b0;
    chk("ovr_cleared", overrun, 1'b0);

    // New edge on line 3 in the same cycle as its ack.
    req = '0;
    cyc(1);
    chk("sim_pre_grant", grant, 8'h08);
    req = 8'h08; ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    chk("sim_pending3", pending[3], 1'b1);
    chk("sim_no_overrun", overrun, 1'b0);
    wait_gv();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0; req = '0;
    cyc(3);

    // Two lines at the extremes rising together.
    ack = 1'b1;
    req = 8'h81;
    wait_gv();
`ifdef REQ_ARB_FIXED_PRIO_EN
    chk("fixed_first", grant, 8'h80);
    cyc(2);
    chk("fixed_second", grant, 8'h01);
`endif
    cyc(4);
    req = '0; ack = 1'b0;
    cyc(2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      req = N'($urandom);
      ack = $urandom_range(0, 1) == 1;
      clr_overrun = $urandom_range(0, 7) == 0;
      cyc(1);
    end
    req = '0; clr_overrun = 1'b0; ack = 1'b1;
    cyc(20);
    ack = 1'b0;
    cyc(2);
    chk("sb_drained", exp_q.size(), 0);

    // Asynchronous reset while line 6 holds the grant.
    do_reset();
    req = 8'h40;
    wait_gv();
    chk("arst_pre_grant", grant, 8'h40);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_grant", grant, '0);
    chk("arst_gv", grant_valid, 1'b0);
    chk("arst_pending", pending, '0);
    @(negedge clk);
    req = '0;
    rst = 1'b0;
    cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
